tone_sequencer: RTL

Parametrised multi-voice melody player. It drives NUM_VOICES square-wave speaker outputs from per-voice note tables that are loaded at runtime through a write port, so melodies are data rather than hard-coded RTL. It sits between the alarm/clock control logic (start, loop_mode) and the board speaker pins. Voice behaviour is exact: note lengths are exact cycle counts, rests are silent, and one-shot or looped playback completes with a done indication.

---
 rtl/tone_pkg.sv | 39 +++
 rtl/tone_voice.sv | 90 +++++++++
 rtl/tone_sequencer.sv | 98 +++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM encoding, note entry, pitches, durations.
package tone_pkg;

  // Storage widths of a note-table entry
  localparam int unsigned NOTE_HALF_W = 20;
  localparam int unsigned NOTE_DUR_W  = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_HALF_W-1:0] half;
    logic [NOTE_DUR_W-1:0]  dur;
    logic                   last;
  } note_t;

  // Half-periods in cycles of a 50 MHz board clock (clk / (2 * f))
  localparam logic [NOTE_HALF_W-1:0] PITCH_REST = 20'd0;
  localparam logic [NOTE_HALF_W-1:0] PITCH_C4   = 20'd95556;
  localparam logic [NOTE_HALF_W-1:0] PITCH_D4   = 20'd85131;
  localparam logic [NOTE_HALF_W-1:0] PITCH_E4   = 20'd75843;
  localparam logic [NOTE_HALF_W-1:0] PITCH_F4   = 20'd71586;
  localparam logic [NOTE_HALF_W-1:0] PITCH_G4   = 20'd63776;
  localparam logic [NOTE_HALF_W-1:0] PITCH_A4   = 20'd56818;
  localparam logic [NOTE_HALF_W-1:0] PITCH_B4   = 20'd50619;
  localparam logic [NOTE_HALF_W-1:0] PITCH_C5   = 20'd47778;

  // Note lengths at 120 bpm on a 50 MHz clock, built from the 32nd-note base
  localparam logic [NOTE_DUR_W-1:0] DUR_32ND    = 28'd3125000;
  localparam logic [NOTE_DUR_W-1:0] DUR_16TH    = 28'd6250000;
  localparam logic [NOTE_DUR_W-1:0] DUR_8TH     = 28'd12500000;
  localparam logic [NOTE_DUR_W-1:0] DUR_QUARTER = 28'd25000000;
  localparam logic [NOTE_DUR_W-1:0] DUR_HALF    = 28'd50000000;
  localparam logic [NOTE_DUR_W-1:0] DUR_WHOLE   = 28'd100000000;

endpackage

// File: rtl/tone_voice.sv
// One voice: private note table, note/period counters and a square-wave output bit.
module tone_voice
  import tone_pkg::*;
#(
  parameter int unsigned DEPTH_W = 7,
  parameter int unsigned HALF_W  = 20,
  parameter int unsigned DUR_W   = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               clear,
  input  logic               loop_mode,
  input  logic               wr_en,
  input  logic [DEPTH_W-1:0] wr_addr,
  input  logic [HALF_W-1:0]  wr_half,
  input  logic [DUR_W-1:0]   wr_dur,
  input  logic               wr_last,
  output logic               speaker,
  output logic               finished
);

  localparam int unsigned DEPTH = 2 ** DEPTH_W;

  note_t              note_mem [DEPTH];
  note_t              cur;
  logic [DEPTH_W-1:0] addr;
  logic [DUR_W-1:0]   dur_cnt;
  logic [HALF_W-1:0]  half_cnt;
  logic [HALF_W-1:0]  half;
  logic [DUR_W-1:0]   dur_end;
  logic               note_end;

  // Table write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      note_mem[wr_addr] <= '{half: NOTE_HALF_W'(wr_half),
                             dur:  NOTE_DUR_W'(wr_dur),
                             last: wr_last};
    end
  end

  // Combinational read from the registered address: no bubble between notes
  assign cur      = note_mem[addr];
  assign half     = HALF_W'(cur.half);
  assign dur_end  = (cur.dur == '0) ? '0 : DUR_W'(cur.dur) - DUR_W'(1);
  assign note_end = (dur_cnt == dur_end);

  // Note sequencing and square-wave generation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr     <= '0;
      dur_cnt  <= '0;
      half_cnt <= '0;
      speaker  <= 1'b0;
      finished <= 1'b0;
    end else if (clear) begin
      addr     <= '0;
      dur_cnt  <= '0;
      half_cnt <= '0;
      speaker  <= 1'b0;
      finished <= 1'b0;
    end else if (play && !finished) begin
      if (note_end) begin
        dur_cnt  <= '0;
        half_cnt <= '0;
        speaker  <= 1'b0;
        if (!cur.last) begin
          addr <= addr + DEPTH_W'(1);
        end else if (loop_mode) begin
          addr <= '0;
        end else begin
          finished <= 1'b1;
        end
      end else begin
        dur_cnt <= dur_cnt + DUR_W'(1);
        if (half == '0) begin
          speaker  <= 1'b0;
          half_cnt <= '0;
        end else if (half_cnt == half - HALF_W'(1)) begin
          speaker  <= ~speaker;
          half_cnt <= '0;
        end else begin
          half_cnt <= half_cnt + HALF_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice melody player: top FSM, table write decode and completion pulse.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 2,
  parameter int unsigned DEPTH_W    = 7,
  parameter int unsigned HALF_W     = 20,
  parameter int unsigned DUR_W      = 28,
  parameter int unsigned VSEL_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  loop_mode,
  input  logic                  wr_en,
  input  logic [VSEL_W-1:0]     wr_voice,
  input  logic [DEPTH_W-1:0]    wr_addr,
  input  logic [HALF_W-1:0]     wr_half,
  input  logic [DUR_W-1:0]      wr_dur,
  input  logic                  wr_last,
  output logic [NUM_VOICES-1:0] speaker,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic                  play;
  logic                  clear;
  logic                  wr_ok;
  logic [NUM_VOICES-1:0] finished;
  logic                  all_finished;

  // Voices advance only while playing; dropping start clears them on the same edge
  assign play         = (state == ST_PLAY) && start;
  assign clear        = !play;
  assign wr_ok        = wr_en && (state == ST_IDLE);
  assign all_finished = &finished;

  // Sequencer FSM with registered busy/done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_PLAY;
            busy  <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (!start) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (all_finished) begin
            state <= ST_HOLD;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!start) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    tone_voice #(
      .DEPTH_W (DEPTH_W),
      .HALF_W  (HALF_W),
      .DUR_W   (DUR_W)
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .play      (play),
      .clear     (clear),
      .loop_mode (loop_mode),
      .wr_en     (wr_ok && (wr_voice == VSEL_W'(v))),
      .wr_addr   (wr_addr),
      .wr_half   (wr_half),
      .wr_dur    (wr_dur),
      .wr_last   (wr_last),
      .speaker   (speaker[v]),
      .finished  (finished[v])
    );
  end

endmodule
